// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices,
// controller state encoding and the stall/flush masks it can drive.
package pipe_pkg;

    localparam int unsigned STG_PC    = 0;
    localparam int unsigned STG_IFID  = 1;
    localparam int unsigned STG_IDEX  = 2;
    localparam int unsigned STG_EXMEM = 3;
    localparam int unsigned STG_MEMWB = 4;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_DIV = 1'b1
    } state_e;

    // One-hot mask selecting a single pipeline register.
    function automatic logic [4:0] stg_mask(input int unsigned stg);
        return 5'(1) << stg;
    endfunction

    localparam logic [4:0] MASK_NONE   = 5'b00000;
    localparam logic [4:0] STALL_ALL   = 5'b11111;
    localparam logic [4:0] FLUSH_RESET = 5'b11110;
    localparam logic [4:0] STALL_DIV   = stg_mask(STG_PC) | stg_mask(STG_IFID) | stg_mask(STG_IDEX);
    localparam logic [4:0] FLUSH_DIV   = stg_mask(STG_EXMEM);
    localparam logic [4:0] STALL_LU    = stg_mask(STG_PC) | stg_mask(STG_IFID);
    localparam logic [4:0] FLUSH_LU    = stg_mask(STG_IDEX);
    localparam logic [4:0] FLUSH_BR    = stg_mask(STG_IFID);

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard request / stall-flush response bundle between the pipeline and
// the hazard controller.
interface pipe_hazard_ctrl_if;

    logic        pause_id;
    logic        br_taken_id;
    logic        div_start_ex;
    logic        div_done;
    logic        mem_busy;
    logic [4:0]  stall_o;
    logic [4:0]  flush_o;
    logic        div_busy_o;
    logic        div_timeout_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] bubble_cnt_o;

    // Pipeline side: raises hazards, consumes stall/flush.
    modport master (
        output pause_id, br_taken_id, div_start_ex, div_done, mem_busy,
        input  stall_o, flush_o, div_busy_o, div_timeout_o, stall_cnt_o, bubble_cnt_o
    );

    // Controller side.
    modport slave (
        input  pause_id, br_taken_id, div_start_ex, div_done, mem_busy,
        output stall_o, flush_o, div_busy_o, div_timeout_o, stall_cnt_o, bubble_cnt_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt32.sv
// Free-running 32-bit event counter; wraps modulo 2^32.
module perf_cnt32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    // Count one per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 32'd1;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
//
// state  | meaning
// ST_RUN | normal flow; load-use, branch and divide-issue hazards decoded
// ST_DIV | divide in flight; front end held, bubbles into EX/MEM
//
// mem_busy overrides everything and freezes the controller state.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 6
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic [4:0]         stall;
    logic [4:0]         flush;

    // State, countdown and sticky timeout registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: a memory wait freezes the controller, including ignoring a divide issue.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (!hz.mem_busy) begin
            case (state_q)
                ST_RUN: begin
                    if (hz.div_start_ex) begin
                        state_d = ST_DIV;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    end
                end
                ST_DIV: begin
                    if (hz.div_done) begin
                        state_d = ST_RUN;
                    end else if (cnt_q == '0) begin
                        state_d   = ST_RUN;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Mealy stall/flush decode so hazards act in the cycle they appear.
    always_comb begin
        stall = MASK_NONE;
        flush = MASK_NONE;
        if (!rst) begin
            flush = FLUSH_RESET;
        end else if (hz.mem_busy) begin
            stall = STALL_ALL;
        end else if (state_q == ST_DIV || hz.div_start_ex) begin
            stall = STALL_DIV;
            flush = FLUSH_DIV;
        end else if (hz.pause_id) begin
            // The branch is re-decoded next cycle, so it is ignored here.
            stall = STALL_LU;
            flush = FLUSH_LU;
        end else if (hz.br_taken_id && DELAY_SLOT == 0) begin
            flush = FLUSH_BR;
        end
    end

    assign hz.stall_o       = stall;
    assign hz.flush_o       = flush;
    assign hz.div_busy_o    = (state_q == ST_DIV);
    assign hz.div_timeout_o = timeout_q;

    perf_cnt32 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (stall[STG_PC]),
        .cnt_o (hz.stall_cnt_o)
    );

    perf_cnt32 u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (rst && (flush != MASK_NONE)),
        .cnt_o (hz.bubble_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench: two controllers (with and without branch delay slot) driven by the
// same hazard stream and compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int DIV_CYCLES = 32;

    logic clk;
    logic rst;
    logic in_p, in_b, in_s, in_d, in_m;

    int checks   = 0;
    int failures = 0;

    // Model state
    bit          m_div;
    int          m_used;
    bit          m_to;
    logic [31:0] m_scnt;
    logic [31:0] m_bcnt1;
    logic [31:0] m_bcnt0;

    pipe_hazard_ctrl_if hz1 ();
    pipe_hazard_ctrl_if hz0 ();

    assign hz1.pause_id     = in_p;
    assign hz1.br_taken_id  = in_b;
    assign hz1.div_start_ex = in_s;
    assign hz1.div_done     = in_d;
    assign hz1.mem_busy     = in_m;
    assign hz0.pause_id     = in_p;
    assign hz0.br_taken_id  = in_b;
    assign hz0.div_start_ex = in_s;
    assign hz0.div_done     = in_d;
    assign hz0.mem_busy     = in_m;

    pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .DELAY_SLOT(1), .CNT_W(6)) dut1 (
        .clk (clk), .rst (rst), .hz (hz1));
    pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .DELAY_SLOT(0), .CNT_W(6)) dut0 (
        .clk (clk), .rst (rst), .hz (hz0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the priority rules, given current inputs and model state.
    function automatic void exp_out(input bit ds, output logic [4:0] st, output logic [4:0] fl);
        st = 5'b00000;
        fl = 5'b00000;
        if (!rst)                 fl = 5'b11110;
        else if (in_m)            st = 5'b11111;
        else if (m_div || in_s) begin st = 5'b00111; fl = 5'b01000; end
        else if (in_p)          begin st = 5'b00011; fl = 5'b00100; end
        else if (in_b && !ds)     fl = 5'b00010;
    endfunction

    task automatic model_reset();
        m_div = 0; m_used = 0; m_to = 0;
        m_scnt = 0; m_bcnt1 = 0; m_bcnt0 = 0;
    endtask

    // Advance the model across one rising edge (rst high).
    task automatic model_step();
        logic [4:0] st1, fl1, st0, fl0;
        exp_out(1'b1, st1, fl1);
        exp_out(1'b0, st0, fl0);
        if (st1[0]) m_scnt = m_scnt + 1;
        if (fl1 != 0) m_bcnt1 = m_bcnt1 + 1;
        if (fl0 != 0) m_bcnt0 = m_bcnt0 + 1;
        if (!in_m) begin
            if (!m_div) begin
                if (in_s) begin m_div = 1; m_used = 0; end
            end else if (in_d) begin
                m_div = 0;
            end else if (m_used == DIV_CYCLES - 1) begin
                m_div = 0; m_to = 1;
            end else begin
                m_used++;
            end
        end
    endtask

    task automatic compare_all();
        logic [4:0] st, fl;
        exp_out(1'b1, st, fl);
        check("ds1_stall",   32'(hz1.stall_o), 32'(st));
        check("ds1_flush",   32'(hz1.flush_o), 32'(fl));
        check("ds1_busy",    32'(hz1.div_busy_o), 32'(m_div));
        check("ds1_timeout", 32'(hz1.div_timeout_o), 32'(m_to));
        check("ds1_scnt",    hz1.stall_cnt_o, m_scnt);
        check("ds1_bcnt",    hz1.bubble_cnt_o, m_bcnt1);
        exp_out(1'b0, st, fl);
        check("ds0_stall",   32'(hz0.stall_o), 32'(st));
        check("ds0_flush",   32'(hz0.flush_o), 32'(fl));
        check("ds0_busy",    32'(hz0.div_busy_o), 32'(m_div));
        check("ds0_timeout", 32'(hz0.div_timeout_o), 32'(m_to));
        check("ds0_scnt",    hz0.stall_cnt_o, m_scnt);
        check("ds0_bcnt",    hz0.bubble_cnt_o, m_bcnt0);
    endtask

    // One clock: model steps on the edge, new inputs 1 ns later, compare on the falling edge.
    task automatic cycle(input bit r, input bit p, input bit b, input bit s, input bit d, input bit m);
        @(posedge clk);
        if (rst) model_step();
        else     model_reset();
        #1;
        rst = r; in_p = p; in_b = b; in_s = s; in_d = d; in_m = m;
        if (!rst) model_reset();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int n;
        rst = 1'b0;
        in_p = 0; in_b = 0; in_s = 0; in_d = 0; in_m = 0;
        model_reset();

        // Reset
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
        check("lit_reset_flush", 32'(hz1.flush_o), 32'h1e);
        check("lit_reset_stall", 32'(hz1.stall_o), 32'h0);
        cycle(1, 0, 0, 0, 0, 0);
        check("lit_idle_flush", 32'(hz1.flush_o), 32'h0);
        check("lit_idle_scnt", hz1.stall_cnt_o, 32'd0);

        // Load-use pulse
        cycle(1, 1, 0, 0, 0, 0);
        check("lit_lu_stall", 32'(hz1.stall_o), 32'h03);
        check("lit_lu_flush", 32'(hz1.flush_o), 32'h04);
        cycle(1, 0, 0, 0, 0, 0);
        check("lit_lu_stall_after", 32'(hz1.stall_o), 32'h0);
        check("lit_lu_scnt", hz1.stall_cnt_o, 32'd1);
        check("lit_lu_bcnt", hz1.bubble_cnt_o, 32'd1);

        // Divide finished by div_done after 5 cycles
        n = 0;
        cycle(1, 0, 0, 1, 0, 0);
        if (hz1.stall_o == 5'b00111) n++;
        for (int k = 1; k <= 5; k++) begin
            cycle(1, 0, 0, 0, (k == 5), 0);
            if (hz1.stall_o == 5'b00111) n++;
        end
        cycle(1, 0, 0, 0, 0, 0);
        check("lit_div_stalled_cycles", 32'(n), 32'd6);
        check("lit_div_back_run", 32'(hz1.stall_o), 32'h0);
        check("lit_div_no_timeout", 32'(hz1.div_timeout_o), 32'd0);

        // Divide timeout
        cycle(1, 0, 0, 1, 0, 0);
        n = 1;
        for (int k = 0; k < 60; k++) begin
            cycle(1, 0, 0, 0, 0, 0);
            if (hz1.stall_o == 5'b00111) n++;
            else break;
        end
        check("lit_timeout_stalled_cycles", 32'(n), 32'd33);
        check("lit_timeout_flag", 32'(hz1.div_timeout_o), 32'd1);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0);
        check("lit_timeout_sticky", 32'(hz1.div_timeout_o), 32'd1);

        // mem_busy for 3 cycles mid-divide
        cycle(1, 0, 0, 1, 0, 0);
        n = 1;
        for (int k = 0; k < 10; k++) begin
            cycle(1, 0, 0, 0, 0, 0);
            if (hz1.stall_o[0]) n++;
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 0, 0, 1);
            check("lit_mem_stall", 32'(hz1.stall_o), 32'h1f);
            if (hz1.stall_o[0]) n++;
        end
        for (int k = 0; k < 60; k++) begin
            cycle(1, 0, 0, 0, 0, 0);
            if (hz1.stall_o[0]) n++;
            else break;
        end
        check("lit_mem_extended_cycles", 32'(n), 32'd36);

        // Branch handling
        cycle(1, 0, 1, 0, 0, 0);
        check("lit_br_ds0", 32'(hz0.flush_o), 32'h02);
        check("lit_br_ds1", 32'(hz1.flush_o), 32'h00);
        cycle(1, 1, 1, 0, 0, 0);
        check("lit_br_lu_ds0", 32'(hz0.flush_o), 32'h04);
        check("lit_br_lu_ds1", 32'(hz1.flush_o), 32'h04);

        // Reset mid-divide
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("lit_rst_busy", 32'(hz1.div_busy_o), 32'd0);
        check("lit_rst_timeout", 32'(hz1.div_timeout_o), 32'd0);
        check("lit_rst_scnt", hz1.stall_cnt_o, 32'd0);
        cycle(1, 0, 0, 0, 0, 0);
        check("lit_rst_run", 32'(hz1.stall_o), 32'h0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(99) != 0),
                  ($urandom_range(99) < 20),
                  ($urandom_range(99) < 20),
                  ($urandom_range(99) < 6),
                  ($urandom_range(99) < 4),
                  ($urandom_range(99) < 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
